// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared encodings and the load-use predicate for the
// ID/EX pipeline stage.
//   result_src_e : ResultSrc mux encodings (ALU result, load data, PC+4)
//   ALU_*        : ALUControl encodings
//   load_use()   : true when the instruction in EX is a load whose
//                  destination feeds a source register of the D instruction
package id_ex_stage_pkg;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } result_src_e;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // x0 is never a real destination, so it can never cause a stall.
   // Both source indices are compared even for stores (Rs2 is the store
   // data); this is conservative on purpose.
   function automatic logic load_use(input logic       valid_e,
                                     input logic [1:0] res_src_e,
                                     input logic [4:0] rd_e,
                                     input logic [4:0] rs1_d,
                                     input logic [4:0] rs2_d);
      return valid_e && (res_src_e == RES_LOAD) && (rd_e != 5'd0) &&
             ((rd_e == rs1_d) || (rd_e == rs2_d));
   endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use / control hazard logic.
//   ValidE, ResultSrcE, RdE : state of the instruction currently in EX
//   Rs1D, Rs2D              : source indices of the instruction in D
//   PCSrcE                  : branch/jump taken, resolved in EX
//   StallF, StallD          : freeze PC and IF/ID register
//   FlushD                  : clear IF/ID register
//   FlushE                  : load a bubble into ID/EX on the next edge
module hazard_detect
   import id_ex_stage_pkg::*;
(
   input  logic       ValidE,
   input  logic [1:0] ResultSrcE,
   input  logic [4:0] RdE,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic       PCSrcE,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE
);

   logic lw_stall;

   assign lw_stall = load_use(ValidE, ResultSrcE, RdE, Rs1D, Rs2D);

   // A taken branch discards the stalled instruction anyway, so it wins
   // over the stall; the bubble still comes from FlushE.
   assign StallF = lw_stall & ~PCSrcE;
   assign StallD = lw_stall & ~PCSrcE;
   assign FlushD = PCSrcE;
   assign FlushE = PCSrcE | lw_stall;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register of the 5-stage core.
//   clk, rst        : core clock; asynchronous active-low reset
//   *D inputs       : decoded control word, operands, immediate, PC, indices
//   PCSrcE          : branch/jump taken in EX
//   *E outputs      : registered copy of the D inputs (zeroed on a bubble)
//   ValidE          : EX slot holds a real instruction
//   StallF/StallD   : load-use stall towards IF and ID
//   FlushD          : clear IF/ID on a taken branch/jump
//   BubbleCount     : saturating count of bubbles inserted
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             RegWriteD,
   input  logic [1:0]       ResultSrcD,
   input  logic             MemWriteD,
   input  logic             JumpD,
   input  logic             BranchD,
   input  logic [2:0]       ALUControlD,
   input  logic             ALUSrcD,
   input  logic [XLEN-1:0]  RD1D,
   input  logic [XLEN-1:0]  RD2D,
   input  logic [XLEN-1:0]  ImmExtD,
   input  logic [XLEN-1:0]  PCD,
   input  logic [XLEN-1:0]  PCPlus4D,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       RdD,
   input  logic             PCSrcE,
   output logic             RegWriteE,
   output logic             MemWriteE,
   output logic             JumpE,
   output logic             BranchE,
   output logic             ALUSrcE,
   output logic [1:0]       ResultSrcE,
   output logic [2:0]       ALUControlE,
   output logic [XLEN-1:0]  RD1E,
   output logic [XLEN-1:0]  RD2E,
   output logic [XLEN-1:0]  ImmExtE,
   output logic [XLEN-1:0]  PCE,
   output logic [XLEN-1:0]  PCPlus4E,
   output logic [4:0]       Rs1E,
   output logic [4:0]       Rs2E,
   output logic [4:0]       RdE,
   output logic             ValidE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic [CNT_W-1:0] BubbleCount
);

   logic flush_e;

   hazard_detect u_hzd (
      .ValidE     (ValidE),
      .ResultSrcE (ResultSrcE),
      .RdE        (RdE),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .PCSrcE     (PCSrcE),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .FlushE     (flush_e)
   );

   // A bubble clears everything, not just control, so a bubble in EX is
   // indistinguishable from the reset state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || flush_e) begin
         if (!rst) begin
            ValidE <= 1'b0;
         end else begin
            ValidE <= 1'b0;
         end
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ResultSrcE  <= 2'b00;
         ALUControlE <= 3'b000;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         PCE         <= '0;
         PCPlus4E    <= '0;
         Rs1E        <= 5'd0;
         Rs2E        <= 5'd0;
         RdE         <= 5'd0;
      end else begin
         ValidE      <= 1'b1;
         RegWriteE   <= RegWriteD;
         MemWriteE   <= MemWriteD;
         JumpE       <= JumpD;
         BranchE     <= BranchD;
         ALUSrcE     <= ALUSrcD;
         ResultSrcE  <= ResultSrcD;
         ALUControlE <= ALUControlD;
         RD1E        <= RD1D;
         RD2E        <= RD2D;
         ImmExtE     <= ImmExtD;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
         RdE         <= RdD;
      end
   end

   // Saturating bubble counter: one count per bubble edge, even when a
   // taken branch and a load-use stall coincide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         BubbleCount <= '0;
      end else if (flush_e && (BubbleCount != {CNT_W{1'b1}})) begin
         BubbleCount <= BubbleCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage. A reference model of the
// EX slot computes the expected E outputs and counters when each D word is
// driven; they are queued and compared after the capturing edge. A second
// instance with CNT_W=4 shares all inputs to exercise counter saturation.
module tb_id_ex_stage;

   typedef struct packed {
      logic        rw;
      logic [1:0]  rs;
      logic        mw;
      logic        j;
      logic        b;
      logic [2:0]  alu;
      logic        as;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  rd;
      logic        v;
   } ex_t;

   typedef struct {
      ex_t         e;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } sb_t;

   logic clk;
   logic rst;
   logic pcsrc;
   ex_t  d;
   ex_t  obs, obs4;

   logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
   logic [1:0] ResultSrcE;
   logic [2:0] ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0] Rs1E, Rs2E, RdE;
   logic StallF, StallD, FlushD;
   logic [15:0] BubbleCount;

   logic RegWriteE4, MemWriteE4, JumpE4, BranchE4, ALUSrcE4, ValidE4;
   logic [1:0] ResultSrcE4;
   logic [2:0] ALUControlE4;
   logic [31:0] RD1E4, RD2E4, ImmExtE4, PCE4, PCPlus4E4;
   logic [4:0] Rs1E4, Rs2E4, RdE4;
   logic StallF4, StallD4, FlushD4;
   logic [3:0] BubbleCount4;

   int   total = 0;
   int   bad   = 0;
   ex_t  m;
   logic [15:0] mcnt;
   logic [3:0]  mcnt4;
   sb_t  sbq[$];

   id_ex_stage dut (
      .clk(clk), .rst(rst),
      .RegWriteD(d.rw), .ResultSrcD(d.rs), .MemWriteD(d.mw), .JumpD(d.j),
      .BranchD(d.b), .ALUControlD(d.alu), .ALUSrcD(d.as),
      .RD1D(d.rd1), .RD2D(d.rd2), .ImmExtD(d.imm), .PCD(d.pc), .PCPlus4D(d.pc4),
      .Rs1D(d.r1), .Rs2D(d.r2), .RdD(d.rd), .PCSrcE(pcsrc),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
      .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
      .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .ValidE(ValidE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .BubbleCount(BubbleCount)
   );

   id_ex_stage #(.XLEN(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .RegWriteD(d.rw), .ResultSrcD(d.rs), .MemWriteD(d.mw), .JumpD(d.j),
      .BranchD(d.b), .ALUControlD(d.alu), .ALUSrcD(d.as),
      .RD1D(d.rd1), .RD2D(d.rd2), .ImmExtD(d.imm), .PCD(d.pc), .PCPlus4D(d.pc4),
      .Rs1D(d.r1), .Rs2D(d.r2), .RdD(d.rd), .PCSrcE(pcsrc),
      .RegWriteE(RegWriteE4), .MemWriteE(MemWriteE4), .JumpE(JumpE4),
      .BranchE(BranchE4), .ALUSrcE(ALUSrcE4), .ResultSrcE(ResultSrcE4),
      .ALUControlE(ALUControlE4), .RD1E(RD1E4), .RD2E(RD2E4), .ImmExtE(ImmExtE4),
      .PCE(PCE4), .PCPlus4E(PCPlus4E4), .Rs1E(Rs1E4), .Rs2E(Rs2E4), .RdE(RdE4),
      .ValidE(ValidE4), .StallF(StallF4), .StallD(StallD4), .FlushD(FlushD4),
      .BubbleCount(BubbleCount4)
   );

   assign obs = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
                 ALUSrcE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE};
   assign obs4 = {RegWriteE4, ResultSrcE4, MemWriteE4, JumpE4, BranchE4, ALUControlE4,
                  ALUSrcE4, RD1E4, RD2E4, ImmExtE4, PCE4, PCPlus4E4, Rs1E4, Rs2E4,
                  RdE4, ValidE4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic ex_t rnd_ex();
      ex_t x;
      x.rw  = 1'($urandom);
      x.rs  = 2'($urandom_range(0, 2));
      x.mw  = 1'($urandom);
      x.j   = 1'($urandom);
      x.b   = 1'($urandom);
      x.alu = 3'($urandom);
      x.as  = 1'($urandom);
      x.rd1 = $urandom;
      x.rd2 = $urandom;
      x.imm = $urandom;
      x.pc  = $urandom;
      x.pc4 = $urandom;
      x.r1  = 5'($urandom_range(0, 7));
      x.r2  = 5'($urandom_range(0, 7));
      x.rd  = 5'($urandom_range(0, 7));
      x.v   = 1'b0;
      return x;
   endfunction

   // Called just after a falling edge: drives one D word, checks the
   // combinational hazard outputs, queues the expected EX state, then
   // compares it after the capturing rising edge.
   task automatic step(input ex_t din, input logic pc);
      ex_t  nx;
      logic lw, fl;
      sb_t  s;
      d = din;
      d.v = 1'b0;
      pcsrc = pc;
      #1;
      lw = m.v && (m.rs == 2'b01) && (m.rd != 5'd0) &&
           ((m.rd == din.r1) || (m.rd == din.r2));
      chk("hazard", {189'd0, StallF, StallD, FlushD}, {189'd0, lw & ~pc, lw & ~pc, pc});
      chk("hazard4", {189'd0, StallF4, StallD4, FlushD4}, {189'd0, lw & ~pc, lw & ~pc, pc});
      fl = pc | lw;
      if (fl) begin
         nx = '0;
      end else begin
         nx = din;
         nx.v = 1'b1;
      end
      if (fl && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      if (fl && mcnt4 != 4'hF) mcnt4 = mcnt4 + 4'd1;
      s.e = nx;
      s.cnt = mcnt;
      s.cnt4 = mcnt4;
      sbq.push_back(s);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         chk("sb_empty", 192'd1, 192'd0);
      end else begin
         s = sbq.pop_front();
         chk("ex", obs, s.e);
         chk("ex4", obs4, s.e);
         chk("cnt", {176'd0, BubbleCount}, {176'd0, s.cnt});
         chk("cnt4", {188'd0, BubbleCount4}, {188'd0, s.cnt4});
      end
      m = nx;
      @(negedge clk);
   endtask

   initial begin
      ex_t x;
      rst = 1'b0;
      pcsrc = 1'b0;
      d = rnd_ex();
      m = '0;
      mcnt = 16'd0;
      mcnt4 = 4'd0;

      // Reset held across several edges with random D inputs.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         d = rnd_ex();
         pcsrc = 1'($urandom);
      end
      @(negedge clk);
      chk("rst_ex", obs, 192'd0);
      chk("rst_ex4", obs4, 192'd0);
      chk("rst_cnt", {176'd0, BubbleCount}, 192'd0);
      rst = 1'b1;

      // First edge after release captures D.
      x = rnd_ex();
      step(x, 1'b0);

      // Plain pass-through.
      x = '0;
      x.rw = 1'b1; x.alu = 3'b010; x.rd1 = 32'h10; x.rd2 = 32'h20; x.rd = 5'd5;
      step(x, 1'b0);

      // Load to x7 followed by a dependent instruction: one bubble, then
      // the re-presented instruction is captured.
      x = rnd_ex(); x.rs = 2'b01; x.rd = 5'd7; x.r1 = 5'd0; x.r2 = 5'd0;
      step(x, 1'b0);
      x = rnd_ex(); x.r1 = 5'd7; x.r2 = 5'd3;
      step(x, 1'b0);
      step(x, 1'b0);

      // Load to x0 never stalls.
      x = rnd_ex(); x.rs = 2'b01; x.rd = 5'd0; x.r1 = 5'd1; x.r2 = 5'd2;
      step(x, 1'b0);
      x = rnd_ex(); x.r1 = 5'd0; x.r2 = 5'd0;
      step(x, 1'b0);

      // Store data dependency (Rs2) together with a taken branch.
      x = rnd_ex(); x.rs = 2'b01; x.rd = 5'd9; x.r1 = 5'd0; x.r2 = 5'd0;
      step(x, 1'b0);
      x = rnd_ex(); x.mw = 1'b1; x.r1 = 5'd1; x.r2 = 5'd9;
      step(x, 1'b1);

      // Consecutive flushes drive the 4-bit counter into saturation.
      for (int i = 0; i < 20; i++) step(rnd_ex(), 1'b1);

      // Random mix with a small register window to provoke hazards.
      for (int i = 0; i < 300; i++) step(rnd_ex(), ($urandom_range(0, 7) == 0));

      // Asynchronous reset mid-cycle.
      #2;
      rst = 1'b0;
      #1;
      chk("arst_ex", obs, 192'd0);
      chk("arst_cnt", {176'd0, BubbleCount}, 192'd0);
      chk("arst_cnt4", {188'd0, BubbleCount4}, 192'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
